// File: rtl/mem_issue_queue.sv
// mem_issue_queue: in-order load/store issue queue. Holds memory ops until their
// operands arrive (dispatch or CDB snoop) and issues them strictly in program
// order through a registered slot that holds while the memory unit stalls.
module mem_issue_queue #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned ROB_W = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    disp_valid,
    output logic                    disp_ready,
    input  logic                    disp_is_store,
    input  logic [31:0]             disp_pc,
    input  logic [31:0]             disp_inst,
    input  logic [31:0]             disp_imm,
    input  logic [ROB_W-1:0]        disp_rob_idx,
    input  logic                    disp_rs1_rdy,
    input  logic                    disp_rs2_rdy,
    input  logic [ROB_W-1:0]        disp_rs1_tag,
    input  logic [ROB_W-1:0]        disp_rs2_tag,
    input  logic [31:0]             disp_rs1_data,
    input  logic [31:0]             disp_rs2_data,
    input  logic                    cdb_valid,
    input  logic [ROB_W-1:0]        cdb_rob_idx,
    input  logic [31:0]             cdb_data,
    input  logic                    mem_stall,
    output logic                    iss_valid,
    output logic                    iss_is_store,
    output logic [31:0]             iss_pc,
    output logic [31:0]             iss_inst,
    output logic [31:0]             iss_imm,
    output logic [31:0]             iss_rs1_data,
    output logic [31:0]             iss_rs2_data,
    output logic [ROB_W-1:0]        iss_rob_idx,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam logic [PTR_W:0] FullCount = (PTR_W + 1)'(DEPTH);

    // Entry storage
    logic             valid_q    [DEPTH];
    logic             store_q    [DEPTH];
    logic [31:0]      pc_q       [DEPTH];
    logic [31:0]      inst_q     [DEPTH];
    logic [31:0]      imm_q      [DEPTH];
    logic [ROB_W-1:0] rob_q      [DEPTH];
    logic             rs1_rdy_q  [DEPTH];
    logic             rs2_rdy_q  [DEPTH];
    logic [ROB_W-1:0] rs1_tag_q  [DEPTH];
    logic [ROB_W-1:0] rs2_tag_q  [DEPTH];
    logic [31:0]      rs1_data_q [DEPTH];
    logic [31:0]      rs2_data_q [DEPTH];

    logic [PTR_W-1:0] head_q, tail_q;
    logic [PTR_W:0]   count_q, count_d;

    logic        enq, pop, head_ready, slot_free;
    logic        enq_rs1_rdy, enq_rs2_rdy;
    logic [31:0] enq_rs1_data, enq_rs2_data;

    // Handshake, pop decision and enqueue-time CDB bypass
    always_comb begin
        disp_ready = (count_q != FullCount);
        enq        = disp_valid && disp_ready;
        // Head readiness looks only at registered state; a same-cycle CDB hit counts next cycle
        head_ready = valid_q[head_q] && rs1_rdy_q[head_q] &&
                     (!store_q[head_q] || rs2_rdy_q[head_q]);
        slot_free  = !iss_valid || !mem_stall;
        pop        = slot_free && head_ready;

        enq_rs1_rdy  = disp_rs1_rdy || (cdb_valid && (cdb_rob_idx == disp_rs1_tag));
        enq_rs2_rdy  = disp_rs2_rdy || (cdb_valid && (cdb_rob_idx == disp_rs2_tag));
        enq_rs1_data = disp_rs1_rdy ? disp_rs1_data : cdb_data;
        enq_rs2_data = disp_rs2_rdy ? disp_rs2_data : cdb_data;

        count_d = count_q;
        case ({enq, pop})
            2'b10:   count_d = count_q + (PTR_W + 1)'(1);
            2'b01:   count_d = count_q - (PTR_W + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Entry valid bits, CDB wakeup of all waiting operands, and tail write
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                valid_q[i] <= 1'b0;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (valid_q[i] && cdb_valid) begin
                    if (!rs1_rdy_q[i] && (rs1_tag_q[i] == cdb_rob_idx)) begin
                        rs1_rdy_q[i]  <= 1'b1;
                        rs1_data_q[i] <= cdb_data;
                    end
                    if (!rs2_rdy_q[i] && (rs2_tag_q[i] == cdb_rob_idx)) begin
                        rs2_rdy_q[i]  <= 1'b1;
                        rs2_data_q[i] <= cdb_data;
                    end
                end
            end
            if (pop) begin
                valid_q[head_q] <= 1'b0;
            end
            // The tail slot is never valid when enqueuing, so no clash with wakeup above
            if (enq) begin
                valid_q[tail_q]    <= 1'b1;
                store_q[tail_q]    <= disp_is_store;
                pc_q[tail_q]       <= disp_pc;
                inst_q[tail_q]     <= disp_inst;
                imm_q[tail_q]      <= disp_imm;
                rob_q[tail_q]      <= disp_rob_idx;
                rs1_rdy_q[tail_q]  <= enq_rs1_rdy;
                rs2_rdy_q[tail_q]  <= enq_rs2_rdy;
                rs1_tag_q[tail_q]  <= disp_rs1_tag;
                rs2_tag_q[tail_q]  <= disp_rs2_tag;
                rs1_data_q[tail_q] <= enq_rs1_data;
                rs2_data_q[tail_q] <= enq_rs2_data;
            end
        end
    end

    // Head/tail pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) head_q <= head_q + PTR_W'(1);
            if (enq) tail_q <= tail_q + PTR_W'(1);
            count_q <= count_d;
        end
    end

    // Issue slot: load the head when free, clear when free with nothing ready, else hold
    always_ff @(posedge clk) begin
        if (rst) begin
            iss_valid    <= 1'b0;
            iss_is_store <= 1'b0;
            iss_pc       <= '0;
            iss_inst     <= '0;
            iss_imm      <= '0;
            iss_rs1_data <= '0;
            iss_rs2_data <= '0;
            iss_rob_idx  <= '0;
        end else if (flush) begin
            iss_valid <= 1'b0;
        end else if (slot_free) begin
            iss_valid <= head_ready;
            if (head_ready) begin
                iss_is_store <= store_q[head_q];
                iss_pc       <= pc_q[head_q];
                iss_inst     <= inst_q[head_q];
                iss_imm      <= imm_q[head_q];
                iss_rs1_data <= rs1_data_q[head_q];
                iss_rs2_data <= rs2_data_q[head_q];
                iss_rob_idx  <= rob_q[head_q];
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_mem_issue_queue.sv
// Bench for mem_issue_queue: directed vector table, hand-written multi-cycle
// sequences (full/stall/wrap, flush, reset), then random traffic against a
// queue-based reference model.
module tb_mem_issue_queue;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned ROB_W = 4;

    logic              clk = 1'b0;
    logic              rst, flush, disp_valid, disp_ready, disp_is_store;
    logic [31:0]       disp_pc, disp_inst, disp_imm;
    logic [ROB_W-1:0]  disp_rob_idx, disp_rs1_tag, disp_rs2_tag;
    logic              disp_rs1_rdy, disp_rs2_rdy;
    logic [31:0]       disp_rs1_data, disp_rs2_data;
    logic              cdb_valid;
    logic [ROB_W-1:0]  cdb_rob_idx;
    logic [31:0]       cdb_data;
    logic              mem_stall;
    logic              iss_valid, iss_is_store;
    logic [31:0]       iss_pc, iss_inst, iss_imm, iss_rs1_data, iss_rs2_data;
    logic [ROB_W-1:0]  iss_rob_idx;
    logic [$clog2(DEPTH):0] count;

    always #5 clk = ~clk;

    mem_issue_queue #(.DEPTH(DEPTH), .ROB_W(ROB_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_is_store(disp_is_store),
        .disp_pc(disp_pc), .disp_inst(disp_inst), .disp_imm(disp_imm),
        .disp_rob_idx(disp_rob_idx), .disp_rs1_rdy(disp_rs1_rdy), .disp_rs2_rdy(disp_rs2_rdy),
        .disp_rs1_tag(disp_rs1_tag), .disp_rs2_tag(disp_rs2_tag),
        .disp_rs1_data(disp_rs1_data), .disp_rs2_data(disp_rs2_data),
        .cdb_valid(cdb_valid), .cdb_rob_idx(cdb_rob_idx), .cdb_data(cdb_data),
        .mem_stall(mem_stall),
        .iss_valid(iss_valid), .iss_is_store(iss_is_store), .iss_pc(iss_pc),
        .iss_inst(iss_inst), .iss_imm(iss_imm), .iss_rs1_data(iss_rs1_data),
        .iss_rs2_data(iss_rs2_data), .iss_rob_idx(iss_rob_idx), .count(count)
    );

    int checks = 0;
    int errors = 0;
    bit use_model = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct packed {
        logic        st;
        logic [31:0] pc, inst, imm, d1, d2;
        logic [3:0]  rob, t1, t2;
        logic        r1, r2;
    } op_t;

    op_t mq[$];
    op_t mslot;
    bit  mvalid;

    task automatic model_step();
        op_t op;
        bit  enq, free, hr;
        if (rst || flush) begin
            mq.delete();
            mvalid = 1'b0;
            if (rst) mslot = '0;
            return;
        end
        enq  = disp_valid && (mq.size() < DEPTH);
        free = !mvalid || !mem_stall;
        hr   = (mq.size() > 0) && mq[0].r1 && (!mq[0].st || mq[0].r2);
        if (cdb_valid) begin
            foreach (mq[i]) begin
                if (!mq[i].r1 && mq[i].t1 == cdb_rob_idx) begin
                    mq[i].r1 = 1'b1; mq[i].d1 = cdb_data;
                end
                if (!mq[i].r2 && mq[i].t2 == cdb_rob_idx) begin
                    mq[i].r2 = 1'b1; mq[i].d2 = cdb_data;
                end
            end
        end
        if (free) begin
            if (hr) begin
                mslot  = mq.pop_front();
                mvalid = 1'b1;
            end else begin
                mvalid = 1'b0;
            end
        end
        if (enq) begin
            op.st   = disp_is_store;
            op.pc   = disp_pc;
            op.inst = disp_inst;
            op.imm  = disp_imm;
            op.rob  = disp_rob_idx;
            op.t1   = disp_rs1_tag;
            op.t2   = disp_rs2_tag;
            op.r1   = disp_rs1_rdy || (cdb_valid && cdb_rob_idx == disp_rs1_tag);
            op.r2   = disp_rs2_rdy || (cdb_valid && cdb_rob_idx == disp_rs2_tag);
            op.d1   = disp_rs1_rdy ? disp_rs1_data : cdb_data;
            op.d2   = disp_rs2_rdy ? disp_rs2_data : cdb_data;
            mq.push_back(op);
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic idle();
        rst = 1'b0; flush = 1'b0; mem_stall = 1'b0;
        disp_valid = 1'b0; disp_is_store = 1'b0;
        disp_pc = '0; disp_inst = '0; disp_imm = '0; disp_rob_idx = '0;
        disp_rs1_rdy = 1'b1; disp_rs2_rdy = 1'b1;
        disp_rs1_tag = '0; disp_rs2_tag = '0;
        disp_rs1_data = '0; disp_rs2_data = '0;
        cdb_valid = 1'b0; cdb_rob_idx = '0; cdb_data = '0;
    endtask

    task automatic put_op(input logic st, input logic [3:0] rob, input logic r1,
                          input logic [3:0] t1, input logic [31:0] d1, input logic r2,
                          input logic [3:0] t2, input logic [31:0] d2);
        disp_valid = 1'b1; disp_is_store = st; disp_rob_idx = rob;
        disp_pc = 32'h1000 + (32'(rob) << 2);
        disp_inst = 32'h0000_0003 | (32'(rob) << 7);
        disp_imm = 32'd4;
        disp_rs1_rdy = r1; disp_rs1_tag = t1; disp_rs1_data = d1;
        disp_rs2_rdy = r2; disp_rs2_tag = t2; disp_rs2_data = d2;
    endtask

    task automatic step();
        if (use_model) model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_slot(input string tag, input logic [3:0] rob, input logic [31:0] d1);
        chk({tag, "_valid"}, 32'(iss_valid), 32'd1);
        chk({tag, "_rob"}, 32'(iss_rob_idx), 32'(rob));
        chk({tag, "_rs1"}, iss_rs1_data, d1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic dv, st, r1, r2;
        logic [3:0] rob, t1, t2;
        logic [31:0] d1, d2;
        logic cv; logic [3:0] ct; logic [31:0] cd;
        logic stall;
        logic ev, est; logic [3:0] erob; logic [31:0] ed1, ed2; logic [3:0] ecnt;
    } vec_t;

    function automatic vec_t idle_row(input logic ev, input logic est, input logic [3:0] erob,
                                      input logic [31:0] ed1, input logic [31:0] ed2,
                                      input logic [3:0] ecnt);
        vec_t v;
        v = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0,
              1'b0, 4'd0, 32'h0, 1'b0, ev, est, erob, ed1, ed2, ecnt};
        return v;
    endfunction

    vec_t vt[16];

    initial begin
        vt[0]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd0, 4'd0, 32'h40, 32'h0,
                   1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd1};
        vt[1]  = idle_row(1'b1, 1'b0, 4'd1, 32'h40, 32'h0, 4'd0);
        vt[2]  = '{1'b1, 1'b1, 1'b1, 1'b0, 4'd2, 4'd0, 4'd3, 32'h100, 32'h0,
                   1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd1};
        vt[3]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd4, 4'd0, 4'd0, 32'h200, 32'h0,
                   1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd2};
        vt[4]  = idle_row(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd2);
        vt[5]  = '{1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 32'h0, 32'h0,
                   1'b1, 4'd3, 32'hDEAD, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd2};
        vt[6]  = idle_row(1'b1, 1'b1, 4'd2, 32'h100, 32'hDEAD, 4'd1);
        vt[7]  = idle_row(1'b1, 1'b0, 4'd4, 32'h200, 32'h0, 4'd0);
        vt[8]  = idle_row(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd0);
        vt[9]  = '{1'b1, 1'b0, 1'b0, 1'b1, 4'd6, 4'd5, 4'd0, 32'h0, 32'h0,
                   1'b1, 4'd5, 32'hBEEF, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd1};
        vt[10] = idle_row(1'b1, 1'b0, 4'd6, 32'hBEEF, 32'h0, 4'd0);
        vt[11] = idle_row(1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd0);
        vt[12] = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd7, 4'd0, 4'd9, 32'h300, 32'h0,
                   1'b0, 4'd0, 32'h0, 1'b0, 1'b0, 1'b0, 4'd0, 32'h0, 32'h0, 4'd1};
        vt[13] = idle_row(1'b1, 1'b0, 4'd7, 32'h300, 32'h0, 4'd0);
        vt[14] = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd8, 4'd0, 4'd0, 32'h500, 32'h0,
                   1'b0, 4'd0, 32'h0, 1'b1, 1'b1, 1'b0, 4'd7, 32'h300, 32'h0, 4'd1};
        vt[15] = idle_row(1'b1, 1'b0, 4'd8, 32'h500, 32'h0, 4'd0);

        // ---- reset ----
        idle();
        rst = 1'b1;
        step();
        step();
        chk("rst_iss_valid", 32'(iss_valid), 32'd0);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_disp_ready", 32'(disp_ready), 32'd1);
        chk("rst_iss_pc", iss_pc, 32'd0);
        chk("rst_iss_rs1", iss_rs1_data, 32'd0);
        rst = 1'b0;

        // ---- table ----
        for (int i = 0; i < 16; i++) begin
            idle();
            if (vt[i].dv)
                put_op(vt[i].st, vt[i].rob, vt[i].r1, vt[i].t1, vt[i].d1,
                       vt[i].r2, vt[i].t2, vt[i].d2);
            cdb_valid = vt[i].cv; cdb_rob_idx = vt[i].ct; cdb_data = vt[i].cd;
            mem_stall = vt[i].stall;
            step();
            chk($sformatf("vec%0d_valid", i), 32'(iss_valid), 32'(vt[i].ev));
            chk($sformatf("vec%0d_count", i), 32'(count), 32'(vt[i].ecnt));
            if (vt[i].ev) begin
                chk($sformatf("vec%0d_rob", i), 32'(iss_rob_idx), 32'(vt[i].erob));
                chk($sformatf("vec%0d_store", i), 32'(iss_is_store), 32'(vt[i].est));
                chk($sformatf("vec%0d_rs1", i), iss_rs1_data, vt[i].ed1);
                chk($sformatf("vec%0d_pc", i), iss_pc, 32'h1000 + (32'(vt[i].erob) << 2));
                chk($sformatf("vec%0d_imm", i), iss_imm, 32'd4);
                if (vt[i].est) chk($sformatf("vec%0d_rs2", i), iss_rs2_data, vt[i].ed2);
            end
        end

        // ---- fill to full under stall, then drain with pointer wrap ----
        for (int k = 0; k < DEPTH; k++) begin
            idle();
            put_op(1'b0, 4'((9 + k) % 16), 1'b1, 4'd0, 32'h1000 + 32'(k), 1'b1, 4'd0, 32'h0);
            mem_stall = 1'b1;
            step();
            chk_slot("full_hold", 4'd8, 32'h500);
            chk("full_count", 32'(count), 32'(k + 1));
            chk("full_disp_ready", 32'(disp_ready), 32'((k + 1) != DEPTH));
        end
        idle();
        put_op(1'b0, 4'd3, 1'b1, 4'd0, 32'hBAD, 1'b1, 4'd0, 32'h0);
        mem_stall = 1'b1;
        step();
        chk("overfill_count", 32'(count), 32'(DEPTH));
        chk_slot("overfill_hold", 4'd8, 32'h500);
        // Full with simultaneous pop: dispatch is still refused
        mem_stall = 1'b0;
        step();
        chk_slot("fullpop", 4'd9, 32'h1000);
        chk("fullpop_count", 32'(count), 32'(DEPTH - 1));
        chk("fullpop_disp_ready", 32'(disp_ready), 32'd1);
        idle();
        for (int k = 1; k < DEPTH; k++) begin
            step();
            chk_slot("drain", 4'((9 + k) % 16), 32'h1000 + 32'(k));
            chk("drain_count", 32'(count), 32'(DEPTH - 1 - k));
        end
        step();
        chk("drain_empty_valid", 32'(iss_valid), 32'd0);
        chk("drain_empty_count", 32'(count), 32'd0);

        // ---- flush with 4 queued and slot held ----
        for (int k = 1; k <= 5; k++) begin
            idle();
            put_op(1'b0, 4'(k), 1'b1, 4'd0, 32'(k), 1'b1, 4'd0, 32'h0);
            mem_stall = 1'b1;
            step();
        end
        chk("preflush_count", 32'(count), 32'd4);
        chk_slot("preflush", 4'd1, 32'd1);
        idle();
        put_op(1'b0, 4'd6, 1'b1, 4'd0, 32'd6, 1'b1, 4'd0, 32'h0);
        mem_stall = 1'b1;
        flush = 1'b1;
        step();
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_valid", 32'(iss_valid), 32'd0);
        chk("flush_disp_ready", 32'(disp_ready), 32'd1);
        idle();
        step();
        step();
        chk("postflush_count", 32'(count), 32'd0);
        chk("postflush_valid", 32'(iss_valid), 32'd0);

        // ---- reset mid-stream with 3 queued ----
        for (int k = 1; k <= 4; k++) begin
            idle();
            put_op(1'b1, 4'(k), 1'b1, 4'd0, 32'(k), 1'b1, 4'd0, 32'hF0 + 32'(k));
            mem_stall = 1'b1;
            step();
        end
        chk("prerst_count", 32'(count), 32'd3);
        chk("prerst_valid", 32'(iss_valid), 32'd1);
        idle();
        put_op(1'b0, 4'd7, 1'b1, 4'd0, 32'd7, 1'b1, 4'd0, 32'h0);
        rst = 1'b1;
        step();
        chk("midrst_valid", 32'(iss_valid), 32'd0);
        chk("midrst_count", 32'(count), 32'd0);
        chk("midrst_disp_ready", 32'(disp_ready), 32'd1);
        chk("midrst_store", 32'(iss_is_store), 32'd0);
        chk("midrst_pc", iss_pc, 32'd0);
        chk("midrst_inst", iss_inst, 32'd0);
        chk("midrst_imm", iss_imm, 32'd0);
        chk("midrst_rs1", iss_rs1_data, 32'd0);
        chk("midrst_rs2", iss_rs2_data, 32'd0);
        chk("midrst_rob", 32'(iss_rob_idx), 32'd0);
        idle();
        step();
        chk("postrst_valid", 32'(iss_valid), 32'd0);
        chk("postrst_count", 32'(count), 32'd0);

        // ---- random traffic against the model (DUT is empty, slot cleared) ----
        mq.delete();
        mslot = '0;
        mvalid = 1'b0;
        use_model = 1'b1;
        for (int n = 0; n < 3000; n++) begin
            idle();
            rst = ($urandom_range(0, 249) == 0);
            flush = ($urandom_range(0, 79) == 0);
            mem_stall = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 9) < 6)
                put_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom,
                       1'($urandom_range(0, 1)), 4'($urandom_range(0, 7)), $urandom);
            cdb_valid = ($urandom_range(0, 9) < 4);
            cdb_rob_idx = 4'($urandom_range(0, 7));
            cdb_data = $urandom;
            step();
            chk("rnd_count", 32'(count), 32'(mq.size()));
            chk("rnd_disp_ready", 32'(disp_ready), 32'(mq.size() != DEPTH));
            chk("rnd_valid", 32'(iss_valid), 32'(mvalid));
            if (mvalid) begin
                chk("rnd_store", 32'(iss_is_store), 32'(mslot.st));
                chk("rnd_rob", 32'(iss_rob_idx), 32'(mslot.rob));
                chk("rnd_pc", iss_pc, mslot.pc);
                chk("rnd_inst", iss_inst, mslot.inst);
                chk("rnd_rs1", iss_rs1_data, mslot.d1);
                if (mslot.st) chk("rnd_rs2", iss_rs2_data, mslot.d2);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mem_issue_queue.md
# mem_issue_queue

In-order load/store issue queue sitting directly upstream of the memory unit. It accepts memory micro-ops from dispatch, holds them until their base and store-data operands are available, and presents them strictly in program order. Operands arrive at dispatch or through common-data-bus (CDB) snooping. Ready ops are presented one at a time through a registered output slot that holds while the memory unit reports a stall.

## Interface
- DEPTH, 8, queue entries; power of two, at least 2
- ROB_W, 4, ROB index width
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  mispredict flush; clears queue and output slot
- disp_valid  in  1  dispatch presents a memory op
- disp_ready  out  1  queue can accept a dispatch this cycle
- disp_is_store  in  1  1 = store, 0 = load
- disp_pc, disp_inst, disp_imm  in  32 each  pc, instruction, sign-extended immediate
- disp_rob_idx  in  ROB_W  ROB slot of this op
- disp_rs1_rdy, disp_rs2_rdy  in  1 each  operand already valid
- disp_rs1_tag, disp_rs2_tag  in  ROB_W each  producer ROB index when not ready
- disp_rs1_data, disp_rs2_data  in  32 each  operand value when ready
- cdb_valid  in  1  CDB broadcast valid
- cdb_rob_idx  in  ROB_W  producer tag
- cdb_data  in  32  produced value
- mem_stall  in  1  memory unit busy; output slot must hold
- iss_valid  out  1  output slot holds an op
- iss_is_store  out  1
- iss_pc, iss_inst, iss_imm, iss_rs1_data, iss_rs2_data  out  32 each
- iss_rob_idx  out  ROB_W
- count  out  $clog2(DEPTH)+1  occupied queue entries (output slot excluded)

## Operation
- Storage: circular buffer, head/tail pointers of $clog2(DEPTH) bits plus a count register; pointers wrap from DEPTH-1 to 0.
- disp_ready = (count != DEPTH). It is 0 when full, even if a pop occurs the same cycle.
- Enqueue occurs when disp_valid && disp_ready. The entry is written at the tail and the tail advances.
- Enqueue-time bypass: if cdb_valid and cdb_rob_idx equals a not-ready disp tag, that operand is stored ready with cdb_data.
- CDB wakeup: every valid entry with a not-ready rs1 (or rs2) whose tag equals cdb_rob_idx captures cdb_data and becomes ready. This applies to all matching entries in the same cycle.
- Head readiness:
  - Loads: rs1 ready.
  - Stores: rs1 and rs2 ready.
  - rs2 of a load is don't-care.
  - Readiness is evaluated on registered state only; a same-cycle CDB hit on the head makes it ready next cycle.
- Output slot advance: slot_free = !iss_valid || !mem_stall.
  - If slot_free and the head is valid and ready: the head is popped into the slot and iss_valid=1 next cycle.
  - Else if slot_free: iss_valid=0 next cycle.
  - Else (mem_stall with iss_valid=1): all iss_* fields hold unchanged.
- Ordering: no younger op bypasses a non-ready head.
- Count update: +1 on enqueue only, -1 on pop only, unchanged when both or neither occur.
- Flush: on the next edge, count, head and tail go to 0, all entry valids go to 0, and iss_valid goes to 0. A dispatch in the flush cycle is discarded. Flush has priority over every other event.

## Timing
- Reset values:
  - iss_valid=0; all iss_* data fields 0; count=0; disp_ready=1.
  - Head and tail pointers 0; all entries invalid.
- Minimum latency:
  - Op dispatched ready at edge E is head at E and popped at edge E+1.
  - iss_valid is high after E+1 (2 cycles from the dispatch cycle to the issue cycle).
- Throughput: one pop per cycle when mem_stall=0 and the head is ready.
- Reset mid-operation: identical to flush; all pending state is dropped.
- Full with simultaneous pop: no enqueue; count becomes DEPTH-1.
- Empty: iss_valid drops after the slot is consumed; count stays 0.

## Test plan
- Reset, then dispatch a ready load (pc=0x1000, rs1=0x40, imm=4) with mem_stall=0 -> iss_valid high exactly 2 cycles after dispatch with iss_rs1_data=0x40, iss_imm=4; count returns to 0.
- Dispatch store S (rs2 tag=3, not ready), then ready load L -> nothing issues. Broadcast cdb_rob_idx=3, data=0xDEAD -> S issues with iss_rs2_data=0xDEAD, then L issues the following cycle, never before S.
- Dispatch DEPTH ready ops while mem_stall=1 with the slot occupied -> disp_ready=0 at count=DEPTH; iss_* hold constant. Release the stall -> one op issues per cycle; the pointers wrap and order is preserved.
- In the same cycle as a CDB broadcast of tag 5, dispatch a load with rs1 tag 5 not ready -> the entry captures cdb_data and issues without a second broadcast.
- With 4 entries queued and iss_valid=1 under mem_stall, assert flush -> next cycle count=0, iss_valid=0, disp_ready=1; the concurrent dispatch is not enqueued.
- Assert rst mid-stream with 3 entries queued -> all outputs at reset values the next cycle.
